vga_timing: RTL and testbench
=============================

# vga_timing

Raster timing generator for the VGA display path. It divides the system clock down to a pixel rate and scans the pixel position counters `x` and `y`. It produces the `hsync`, `vsync` and `blank` signals for the connector. Its `x`/`y` outputs drive the shape and colour generators directly, and `frame_tick` gives game logic a once-per-frame update strobe.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel (50 MHz → 25 MHz pixel rate); allowed range 1..15
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge
- `reset`  in  1: synchronous, active-high reset
- `x`  out  11: horizontal counter, 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800)
- `y`  out  10: vertical counter, 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525)
- `hsync`  out  1: horizontal sync, level set by `SYNC_POL`
- `vsync`  out  1: vertical sync, level set by `SYNC_POL`
- `blank`  out  1: 1 when (`x`,`y`) is outside the visible area
- `pixel_tick`  out  1: high on the last clk of each pixel period
- `frame_tick`  out  1: single-clk pulse on the last clk of the frame

## Operation
- **Divider.** `div` counts 0..CLK_DIV-1 and wraps to 0.
  - `pixel_tick` = (`div` == CLK_DIV-1).
  - With CLK_DIV=1, `pixel_tick` is constantly 1 outside reset.
- **Horizontal counter.** On a clk edge with `pixel_tick`=1, `x` increments. From H_TOTAL-1 it wraps to 0.
- **Vertical counter.** `y` increments only on the edge where `x` wraps. From V_TOTAL-1 it wraps to 0.
- **Counter widths.** `x` and `y` never take values ≥ H_TOTAL / V_TOTAL. Compare with `==`, not overflow, so non-power-of-two totals work.
- **Registered outputs.** `hsync`, `vsync` and `blank` are registered from the next-state counter values. In every cycle they describe the current `x`/`y`; there is no skew between position and sync.
  - `hsync` asserted iff H_ACTIVE+H_FP ≤ `x` < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vsync` asserted iff V_ACTIVE+V_FP ≤ `y` < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `blank` = (`x` ≥ H_ACTIVE) | (`y` ≥ V_ACTIVE).
- **Frame tick.** `frame_tick` = `pixel_tick` & (`x` == H_TOTAL-1) & (`y` == V_TOTAL-1). It is exactly one clk wide, once per frame.
- **Downstream contract.** Consumers sample `x`/`y` combinationally. The values are stable for CLK_DIV clks per pixel.
- **Reset.** Reset has priority over counting.
- **Reset values**, presented on the clk after the reset edge:
  - `div`=0, `x`=0, `y`=0
  - `hsync`=`vsync`=~SYNC_POL (deasserted)
  - `blank`=0
  - `frame_tick`=0
  - `pixel_tick`=(CLK_DIV==1)
- **Reset mid-frame.** All counters return to 0 at once, with no partial line or frame completion.
- **No state machine.** Counter state alone defines the phase: active, front porch, sync, back porch.

## Timing
- Line period: H_TOTAL·CLK_DIV = 1600 clk.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV = 840 000 clk (16.8 ms at 50 MHz, about 59.5 Hz).
- Latency from `reset` deassertion to the first `x` increment: CLK_DIV clk edges.
- `hsync` pulse width: H_SYNC·CLK_DIV = 192 clk.
- `vsync` pulse width: V_SYNC lines = 3200 clk.
- `vsync` edges coincide with the clk on which `x` becomes 0.
- `frame_tick` is followed on the next clk by `x`=0, `y`=0, `blank`=0.

## Test plan
- **Reset values.** Hold `reset` 3 clk, release → `x`=0, `y`=0, `hsync`=1, `vsync`=1, `blank`=0, `frame_tick`=0. `x`=1 first appears exactly 2 clk after release.
- **Horizontal timing.** Run one line → `blank` rises at `x`=640. `hsync` is low for `x` 656..751, exactly 192 clk. `x` wraps 799→0 while `y` goes 0→1. Rising edges of `x`=0 are spaced 1600 clk apart.
- **Vertical timing.** Run one full frame →
  - `blank` stays high for all of `y` 480..524.
  - `vsync` is low only for `y`=490..491, for 3200 clk.
  - `y` wraps 524→0.
  - `frame_tick` fires once, 840 000 clk after the previous one.
- **Reset mid-operation.** Assert `reset` at `x`=700, `y`=491 (sync active) → next clk shows `x`=0, `y`=0, `hsync`=`vsync`=1. No `frame_tick` pulse occurs.
- **Parameter variant.** CLK_DIV=1, SYNC_POL=1 → `pixel_tick` stuck at 1. `x` advances every clk. `hsync` is high for `x` 656..751 (96 clk). The frame is 420 000 clk.
- **Consistency check.** Across a full frame, assert every clk that `blank` == (`x`≥640 | `y`≥480) and that `x`<800, `y`<525.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// A clock divider produces the pixel strobe. Two wrap-on-equality counters
// scan x/y across the full line and frame. Sync and blank are registered from
// the next-state counter values, so they always describe the current x/y
// with no skew between position and sync.
module vga_timing #(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        pixel_tick,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [10:0] X_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_ACTIVE   = 11'(H_ACTIVE);
    localparam logic [10:0] X_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] X_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  Y_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  div_reg, div_next;
    logic [10:0] x_reg, x_next;
    logic [9:0]  y_reg, y_next;
    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        blank_reg, blank_next;
    logic        line_end;

    // Strobes come straight from counter state; with CLK_DIV=1 the divider
    // sits at 0 and pixel_tick is permanently high.
    assign pixel_tick = (div_reg == DIV_LAST);
    assign line_end   = pixel_tick && (x_reg == X_LAST);
    assign frame_tick = line_end && (y_reg == Y_LAST);

    // Next-state counters plus sync/blank decoded from the next position.
    always_comb begin
        div_next = pixel_tick ? 4'd0 : div_reg + 4'd1;
        x_next   = x_reg;
        y_next   = y_reg;
        if (pixel_tick) begin
            x_next = (x_reg == X_LAST) ? 11'd0 : x_reg + 11'd1;
        end
        if (line_end) begin
            y_next = (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;
        end
        hsync_next = ((x_next >= X_SYNC_BEG) && (x_next < X_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((y_next >= Y_SYNC_BEG) && (y_next < Y_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        blank_next = (x_next >= X_ACTIVE) || (y_next >= Y_ACTIVE);
    end

    // State registers; reset wins over counting and restarts the frame at 0,0.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg   <= 4'd0;
            x_reg     <= 11'd0;
            y_reg     <= 10'd0;
            hsync_reg <= ~SYNC_POL;
            vsync_reg <= ~SYNC_POL;
            blank_reg <= 1'b0;
        end else begin
            div_reg   <= div_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            blank_reg <= blank_next;
        end
    end

    assign x     = x_reg;
    assign y     = y_reg;
    assign hsync = hsync_reg;
    assign vsync = vsync_reg;
    assign blank = blank_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Directed testbench for vga_timing.
// Instance a uses the default 640x480 timing for reset and line checks.
// Instance b uses a reduced raster (15x8, CLK_DIV=2, active-low sync) for
// whole-frame and mid-frame reset checks. Instance c uses the same raster
// with CLK_DIV=1 and active-high sync.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    logic [10:0] x_a, x_b, x_c;
    logic [9:0]  y_a, y_b, y_c;
    logic hsync_a, vsync_a, blank_a, pixel_tick_a, frame_tick_a;
    logic hsync_b, vsync_b, blank_b, pixel_tick_b, frame_tick_b;
    logic hsync_c, vsync_c, blank_c, pixel_tick_c, frame_tick_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing dut_a (
        .clk(clk), .reset(rst_a), .x(x_a), .y(y_a), .hsync(hsync_a), .vsync(vsync_a),
        .blank(blank_a), .pixel_tick(pixel_tick_a), .frame_tick(frame_tick_a)
    );

    vga_timing #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .x(x_b), .y(y_b), .hsync(hsync_b), .vsync(vsync_b),
        .blank(blank_b), .pixel_tick(pixel_tick_b), .frame_tick(frame_tick_b)
    );

    vga_timing #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_c (
        .clk(clk), .reset(rst_c), .x(x_c), .y(y_c), .hsync(hsync_c), .vsync(vsync_c),
        .blank(blank_c), .pixel_tick(pixel_tick_c), .frame_tick(frame_tick_c)
    );

    // One comparison: counts it, and on mismatch counts the failure and reports it.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int cyc, done, px, py, pb, pvs;
    int hs_low, hmin, hmax, rise_x, wrap_px, wrap_py, wrap_y, wrap_blank;
    int vs_low, vmin, vmax, bad, tail_bad, wrap_seen, vs_edge_bad, ft_cnt;
    int pt_bad, step_bad, hs_high, hs_bad, exp_x;

    initial begin
        // ---------------- reset values, default timing ----------------
        repeat (3) @(negedge clk);
        check("a_rst_x", 32'(x_a), 0);
        check("a_rst_y", 32'(y_a), 0);
        check("a_rst_hsync", 32'(hsync_a), 1);
        check("a_rst_vsync", 32'(vsync_a), 1);
        check("a_rst_blank", 32'(blank_a), 0);
        check("a_rst_frame_tick", 32'(frame_tick_a), 0);
        check("a_rst_pixel_tick", 32'(pixel_tick_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("a_x_1clk_after_release", 32'(x_a), 0);
        @(negedge clk);
        check("a_x_2clk_after_release", 32'(x_a), 1);
        $display("reset a: x=%0d y=%0d hsync=%0b vsync=%0b", x_a, y_a, hsync_a, vsync_a);

        // ---------------- one line, default timing ----------------
        px = int'(x_a); py = int'(y_a); pb = int'(blank_a);
        cyc = 0; done = 0; hs_low = 0; hmin = 9999; hmax = -1; rise_x = -1;
        wrap_px = -1; wrap_py = -1; wrap_y = -1; wrap_blank = -1;
        while (done == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!hsync_a) begin
                hs_low++;
                if (int'(x_a) < hmin) hmin = int'(x_a);
                if (int'(x_a) > hmax) hmax = int'(x_a);
            end
            if (blank_a && pb == 0 && rise_x < 0) rise_x = int'(x_a);
            if (x_a == 0 && px != 0) begin
                done = 1; wrap_px = px; wrap_py = py;
                wrap_y = int'(y_a); wrap_blank = int'(blank_a);
            end
            px = int'(x_a); py = int'(y_a); pb = int'(blank_a);
        end
        check("a_line_wrap_found", 32'(done), 1);
        check("a_blank_rise_x", 32'(rise_x), 640);
        check("a_hsync_low_clks", 32'(hs_low), 192);
        check("a_hsync_first_x", 32'(hmin), 656);
        check("a_hsync_last_x", 32'(hmax), 751);
        check("a_wrap_prev_x", 32'(wrap_px), 799);
        check("a_wrap_prev_y", 32'(wrap_py), 0);
        check("a_wrap_new_y", 32'(wrap_y), 1);
        check("a_wrap_blank", 32'(wrap_blank), 0);
        $display("line a: blank_rise_x=%0d hsync_low=%0d x%0d..%0d wrap %0d->0 y=%0d",
                 rise_x, hs_low, hmin, hmax, wrap_px, wrap_y);
        cyc = 0; done = 0;
        while (done == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (x_a == 0 && px != 0) done = 1;
            px = int'(x_a);
        end
        check("a_line_period", 32'(cyc), 1600);
        $display("line a: period=%0d clk", cyc);

        // ---------------- full frame, reduced raster ----------------
        rst_b = 1'b0;
        cyc = 0;
        while (!frame_tick_b && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("b_first_frame_tick", 32'(frame_tick_b), 1);
        py = int'(y_b); pvs = int'(vsync_b);
        cyc = 0; vs_low = 0; vmin = 9999; vmax = -1; bad = 0; tail_bad = 0;
        wrap_seen = 0; vs_edge_bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("b_after_tick_x", 32'(x_b), 0);
                check("b_after_tick_y", 32'(y_b), 0);
                check("b_after_tick_blank", 32'(blank_b), 0);
                check("b_tick_width", 32'(frame_tick_b), 0);
            end
            if (blank_b !== ((x_b >= 8) || (y_b >= 4))) bad++;
            if (x_b >= 15 || y_b >= 8) bad++;
            if (y_b >= 4 && !blank_b) tail_bad++;
            if (!vsync_b) begin
                vs_low++;
                if (int'(y_b) < vmin) vmin = int'(y_b);
                if (int'(y_b) > vmax) vmax = int'(y_b);
            end
            if (int'(vsync_b) != pvs && x_b != 0) vs_edge_bad++;
            if (py == 7 && y_b == 0) wrap_seen++;
            py = int'(y_b); pvs = int'(vsync_b);
        end while (!frame_tick_b && cyc < 1000);
        check("b_frame_period", 32'(cyc), 240);
        check("b_blank_consistency", 32'(bad), 0);
        check("b_blank_vertical_tail", 32'(tail_bad), 0);
        check("b_vsync_low_clks", 32'(vs_low), 60);
        check("b_vsync_first_y", 32'(vmin), 5);
        check("b_vsync_last_y", 32'(vmax), 6);
        check("b_vsync_edge_at_x0", 32'(vs_edge_bad), 0);
        check("b_y_wraps", 32'(wrap_seen), 1);
        $display("frame b: period=%0d vsync_low=%0d y%0d..%0d wraps=%0d",
                 cyc, vs_low, vmin, vmax, wrap_seen);

        // ---------------- reset during sync, reduced raster ----------------
        cyc = 0;
        while (!(x_b == 12 && y_b == 6) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("b_reach_sync_point", 32'((x_b == 12) && (y_b == 6)), 1);
        check("b_hsync_active_before_rst", 32'(hsync_b), 0);
        check("b_vsync_active_before_rst", 32'(vsync_b), 0);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_midrst_x", 32'(x_b), 0);
        check("b_midrst_y", 32'(y_b), 0);
        check("b_midrst_hsync", 32'(hsync_b), 1);
        check("b_midrst_vsync", 32'(vsync_b), 1);
        check("b_midrst_frame_tick", 32'(frame_tick_b), 0);
        rst_b = 1'b0;
        ft_cnt = 0;
        @(negedge clk);
        if (frame_tick_b) ft_cnt++;
        @(negedge clk);
        if (frame_tick_b) ft_cnt++;
        check("b_x_after_midrst_release", 32'(x_b), 1);
        repeat (20) begin
            @(negedge clk);
            if (frame_tick_b) ft_cnt++;
        end
        check("b_no_tick_after_midrst", 32'(ft_cnt), 0);
        $display("midrst b: x=%0d y=%0d frame_ticks=%0d", x_b, y_b, ft_cnt);

        // ---------------- CLK_DIV=1, active-high sync ----------------
        check("c_rst_pixel_tick", 32'(pixel_tick_c), 1);
        check("c_rst_hsync", 32'(hsync_c), 0);
        check("c_rst_vsync", 32'(vsync_c), 0);
        rst_c = 1'b0;
        @(negedge clk);
        check("c_x_1clk_after_release", 32'(x_c), 1);
        cyc = 0;
        while (!frame_tick_c && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("c_first_frame_tick", 32'(frame_tick_c), 1);
        px = int'(x_c);
        cyc = 0; pt_bad = 0; step_bad = 0; hs_high = 0; hs_bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!pixel_tick_c) pt_bad++;
            exp_x = (px == 14) ? 0 : px + 1;
            if (int'(x_c) != exp_x) step_bad++;
            if (hsync_c) hs_high++;
            if (hsync_c !== ((x_c >= 10) && (x_c <= 12))) hs_bad++;
            px = int'(x_c);
        end while (!frame_tick_c && cyc < 1000);
        check("c_frame_period", 32'(cyc), 120);
        check("c_pixel_tick_stuck", 32'(pt_bad), 0);
        check("c_x_every_clk", 32'(step_bad), 0);
        check("c_hsync_high_clks", 32'(hs_high), 24);
        check("c_hsync_window", 32'(hs_bad), 0);
        $display("frame c: period=%0d hsync_high=%0d step_bad=%0d", cyc, hs_high, step_bad);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
